// File: rtl/panel_pkg.sv
// Shared defaults and sizing helpers for the front-panel button conditioning blocks.
// Pure constants/functions: no latency, no flow control.
package panel_pkg;

  localparam int DEF_STABLE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY  = 500;
  localparam int DEF_REPEAT_RATE   = 100;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Raw button inputs and conditioned level/press outputs for an N-channel debouncer.
// Plain wires: no latency, no backpressure.
interface button_debouncer_if #(
  parameter int N = 1
);
  logic [N-1:0] buttons_raw;
  logic [N-1:0] level;
  logic [N-1:0] pressed;

  modport master (output buttons_raw, input level, input pressed);
  modport slave  (input buttons_raw, output level, output pressed);
endinterface

// File: rtl/button_debouncer_channel.sv
// One button: 2-flop sync, stability counter, registered level and press pulse.
// Level/pulse land STABLE_CYCLES+2 edges after raw changes; no backpressure.
module debounce_channel
  import panel_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pressed
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (s2 != level) && (cnt == CMAX);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RW-1:0] RDLY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rcnt;
  logic          rphase;  // 0: waiting out the initial delay, 1: steady repeat rate
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      pressed <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt    <= '0;
      rphase  <= 1'b0;
`endif
    end else begin
      s1      <= raw;
      s2      <= s1;
      pressed <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level   <= s2;
        cnt     <= '0;
        pressed <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
`ifdef BTN_AUTOREPEAT_EN
      // A release edge takes the clear branch, so a repeat due on that edge is dropped.
      if (!level || accept) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rcnt == (rphase ? RRATE : RDLY)) begin
        pressed <= 1'b1;
        rcnt    <= '0;
        rphase  <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// N independent debounce channels; pulses from simultaneous presses coincide.
// Latency STABLE_CYCLES+2 edges, no backpressure; BTN_AUTOREPEAT_EN adds auto-repeat pulses.
module button_debouncer
  import panel_pkg::*;
#(
  parameter int N             = 1,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  button_debouncer_if.slave bus
);

  wire [N-1:0] level_w;
  wire [N-1:0] pressed_w;

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (bus.buttons_raw[i]),
      .level  (level_w[i]),
      .pressed(pressed_w[i])
    );
  end

  assign bus.level   = level_w;
  assign bus.pressed = pressed_w;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: expected press pulses are queued at stimulus time and matched by a monitor.
module tb_button_debouncer;

  localparam int N = 4;
  localparam int S = 16;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } pulse_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     e;
  int     r;
  pulse_t exp_q[$];
  pulse_t mon_p;

  button_debouncer_if #(.N(N)) bif ();

  button_debouncer #(
    .N(N),
    .STABLE_CYCLES(S)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(50),
    .REPEAT_RATE(20)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after edge number t.
  task automatic wait_edge(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < t) check("wait_timeout", cyc, t);
  endtask

  task automatic push(input int c, input logic [3:0] v);
    pulse_t p;
    p.cyc = c;
    p.val = v;
    exp_q.push_back(p);
  endtask

  always @(negedge clk) begin
    if (bif.pressed !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, bif.pressed}, 32'd0);
      end else begin
        mon_p = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_p.cyc);
        check("pulse_value", {28'd0, bif.pressed}, {28'd0, mon_p.val});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.buttons_raw = '0;
    rst_n = 1'b0;
    wait_edge(3);
    check("reset_level", {28'd0, bif.level}, 32'd0);
    check("reset_pressed", {28'd0, bif.pressed}, 32'd0);
    rst_n = 1'b1;
    wait_edge(6);

    // Clean press on bit 2
    e = cyc;
    bif.buttons_raw[2] = 1'b1;
    push(e + 18, 4'b0100);
    wait_edge(e + 17);
    check("clean_level_early", {28'd0, bif.level}, 32'd0);
    wait_edge(e + 18);
    check("clean_level", {28'd0, bif.level}, 32'h4);
    check("clean_pressed", {28'd0, bif.pressed}, 32'h4);
    wait_edge(e + 19);
    check("clean_pressed_drop", {28'd0, bif.pressed}, 32'd0);

    // Release of bit 2: level falls, no pulse
    e = cyc;
    bif.buttons_raw[2] = 1'b0;
    wait_edge(e + 17);
    check("release_level_early", {28'd0, bif.level}, 32'h4);
    wait_edge(e + 18);
    check("release_level", {28'd0, bif.level}, 32'd0);
    wait_edge(e + 22);

    // Bounce on bit 0 every 3 cycles, then a final hold
    for (int k = 0; k < 14; k++) begin
      bif.buttons_raw[0] = ~bif.buttons_raw[0];
      wait_edge(cyc + 3);
    end
    check("bounce_level", {28'd0, bif.level}, 32'd0);
    e = cyc;
    bif.buttons_raw[0] = 1'b1;
    push(e + 18, 4'b0001);
    wait_edge(e + 17);
    check("bounce_level_early", {28'd0, bif.level}, 32'd0);
    wait_edge(e + 18);
    check("bounce_level_final", {28'd0, bif.level}, 32'h1);
    bif.buttons_raw[0] = 1'b0;
    wait_edge(cyc + 20);
    check("bounce_release", {28'd0, bif.level}, 32'd0);

    // Simultaneous press on bits 0 and 3
    e = cyc;
    bif.buttons_raw = 4'b1001;
    push(e + 18, 4'b1001);
    wait_edge(e + 18);
    check("simul_pressed", {28'd0, bif.pressed}, 32'h9);
    check("simul_level", {28'd0, bif.level}, 32'h9);
    bif.buttons_raw = 4'b0000;
    wait_edge(cyc + 20);
    check("simul_release", {28'd0, bif.level}, 32'd0);

    // Reset in the middle of qualifying bit 1; button stays held
    e = cyc;
    bif.buttons_raw[1] = 1'b1;
    wait_edge(e + 10);
    rst_n = 1'b0;
    #1;
    check("midreset_level", {28'd0, bif.level}, 32'd0);
    check("midreset_pressed", {28'd0, bif.pressed}, 32'd0);
    wait_edge(e + 13);
    rst_n = 1'b1;
    r = cyc;
    push(r + 18, 4'b0010);
`ifdef BTN_AUTOREPEAT_EN
    push(r + 68, 4'b0010);
    push(r + 88, 4'b0010);
    push(r + 108, 4'b0010);
`endif
    wait_edge(r + 17);
    check("requal_level_early", {28'd0, bif.level}, 32'd0);
    wait_edge(r + 18);
    check("requal_level", {28'd0, bif.level}, 32'h2);
    check("requal_pressed", {28'd0, bif.pressed}, 32'h2);

    // Release so level falls one edge before the next repeat would fire
    wait_edge(r + 109);
    bif.buttons_raw[1] = 1'b0;
    wait_edge(r + 126);
    check("hold_level", {28'd0, bif.level}, 32'h2);
    wait_edge(r + 127);
    check("final_release", {28'd0, bif.level}, 32'd0);
    wait_edge(r + 160);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
